// File: rtl/traffic_light_monitor_if.sv
// traffic_light_monitor_if -- observation bus between the light controller
// outputs and traffic_light_monitor.
//   master : drives light_hospital/light_highway/fault_clr, reads status
//   slave  : the monitor (reads lights, drives phase/fault/cycle_count)
`timescale 1ns/1ps
interface traffic_light_monitor_if;
  logic [2:0]  light_hospital;   // {red,yellow,green}
  logic [2:0]  light_highway;    // {red,yellow,green}
  logic        fault_clr;        // one-cycle clear/resync pulse
  logic [1:0]  phase;            // decoded controller phase
  logic        phase_valid;      // locked to a legal phase
  logic        phase_change;     // one-cycle pulse per legal transition
  logic        fault;            // sticky fault flag
  logic [2:0]  fault_code;       // first fault captured
  logic [15:0] cycle_count;      // completed full cycles

  modport master (
    output light_hospital, light_highway, fault_clr,
    input  phase, phase_valid, phase_change, fault, fault_code, cycle_count
  );

  modport slave (
    input  light_hospital, light_highway, fault_clr,
    output phase, phase_valid, phase_change, fault, fault_code, cycle_count
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor -- receive-side checker for the two-road light
// controller. Decodes the light buses back into the controller phase,
// tracks the 00->01->10->11 sequence, measures dwell in ticks and latches
// the first encoding/conflict/sequence/timing fault.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   mon   : traffic_light_monitor_if.slave (lights in, status out)
// Optional feature: define TRAFFIC_MON_STATS_EN to build the saturating
// cycle_count (11->00 transitions); otherwise cycle_count is tied to 0.
`timescale 1ns/1ps
module traffic_light_monitor #(
  parameter int TICK_DIV  = 4,
  parameter int YEL_TICKS = 3,
  parameter int GRN_TICKS = 10,
  parameter int TOL       = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  traffic_light_monitor_if.slave  mon
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [8:0] YEL_LO = 9'(YEL_TICKS - TOL);
  localparam logic [8:0] YEL_HI = 9'(YEL_TICKS + TOL);
  localparam logic [8:0] GRN_LO = 9'(GRN_TICKS - TOL);
  localparam logic [8:0] GRN_HI = 9'(GRN_TICKS + TOL);

  typedef enum logic [1:0] {ST_SYNC, ST_MON, ST_FAULT} state_t;

  state_t      state, state_nxt;
  logic [2:0]  hosp_q, hway_q;
  logic [PW-1:0] psc;
  logic        tick;
  logic [7:0]  dwell, dwell_nxt;
  logic        first_phase, first_nxt;
  logic [1:0]  phase_r, phase_nxt;
  logic        pv_r, chg_r, chg_nxt;
  logic        fault_r, fault_nxt;
  logic [2:0]  code_r, code_nxt, det;
  logic        pair_ok, stay_ok, step_ok, enc_bad, conflict;
  logic [1:0]  pair_ph;
  logic        has_lim, short_exit, long_now;
  logic [8:0]  lim_lo, lim_hi;

  function automatic logic onehot3(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  // Input capture. Reset to all-red so the first post-reset cycle decodes
  // as a harmless non-phase instead of an illegal encoding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hosp_q <= 3'b100;
      hway_q <= 3'b100;
    end else begin
      hosp_q <= mon.light_hospital;
      hway_q <= mon.light_highway;
    end
  end

  // Tick prescaler
  assign tick = (psc == PW'(TICK_DIV - 1));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    psc <= '0;
    else if (tick) psc <= '0;
    else           psc <= psc + 1'b1;
  end

  // Pair decode
  always_comb begin
    pair_ok = 1'b1;
    pair_ph = 2'd0;
    case ({hosp_q, hway_q})
      {3'b001, 3'b100}: pair_ph = 2'd0;
      {3'b010, 3'b100}: pair_ph = 2'd1;
      {3'b100, 3'b001}: pair_ph = 2'd2;
      {3'b100, 3'b010}: pair_ph = 2'd3;
      default:          pair_ok = 1'b0;
    endcase
  end

  assign enc_bad  = !onehot3(hosp_q) || !onehot3(hway_q);
  assign conflict = !enc_bad && !hosp_q[2] && !hway_q[2];
  assign stay_ok  = pair_ok && (pair_ph == phase_r);
  assign step_ok  = pair_ok && (pair_ph == 2'(phase_r + 2'd1));

  // Dwell limits of the current phase; hospital green is unbounded
  always_comb begin
    has_lim = 1'b1;
    lim_lo  = YEL_LO;
    lim_hi  = YEL_HI;
    if (phase_r == 2'd0) has_lim = 1'b0;
    if (phase_r == 2'd2) begin
      lim_lo = GRN_LO;
      lim_hi = GRN_HI;
    end
  end

  // Exit dwell uses the count before any same-cycle tick
  assign short_exit = has_lim && !first_phase && ({1'b0, dwell} < lim_lo);
  assign long_now   = has_lim && tick && stay_ok && (({1'b0, dwell} + 9'd1) > lim_hi);

  // Fault detection, lowest code wins
  always_comb begin
    det = 3'd0;
    if (enc_bad)                                   det = 3'd1;
    else if (conflict)                             det = 3'd2;
    else if (state == ST_MON && pair_ok && !stay_ok && !step_ok) det = 3'd3;
    else if (state == ST_MON && step_ok && short_exit)           det = 3'd4;
    else if (state == ST_MON && long_now)                        det = 3'd5;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_SYNC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = phase_r;
    dwell_nxt = dwell;
    first_nxt = first_phase;
    chg_nxt   = 1'b0;
    fault_nxt = fault_r;
    code_nxt  = code_r;
    // A clear is overridden below by a fault captured in the same cycle
    if (mon.fault_clr) begin
      fault_nxt = 1'b0;
      code_nxt  = 3'd0;
    end
    case (state)
      ST_SYNC: begin
        if (det != 3'd0) begin
          fault_nxt = 1'b1;
          code_nxt  = det;
          state_nxt = ST_FAULT;
        end else if (pair_ok) begin
          state_nxt = ST_MON;
          phase_nxt = pair_ph;
          dwell_nxt = 8'd0;
          first_nxt = 1'b1;
        end
      end
      ST_MON: begin
        if (det != 3'd0) begin
          fault_nxt = 1'b1;
          code_nxt  = det;
          state_nxt = ST_FAULT;
        end else if (step_ok) begin
          chg_nxt   = 1'b1;
          phase_nxt = pair_ph;
          dwell_nxt = tick ? 8'd1 : 8'd0;
          first_nxt = 1'b0;
        end else if (tick && dwell != 8'hFF) begin
          dwell_nxt = dwell + 8'd1;
        end
      end
      ST_FAULT: begin
        if (mon.fault_clr) state_nxt = ST_SYNC;
      end
      default: state_nxt = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_r     <= 2'd0;
      pv_r        <= 1'b0;
      chg_r       <= 1'b0;
      fault_r     <= 1'b0;
      code_r      <= 3'd0;
      dwell       <= 8'd0;
      first_phase <= 1'b0;
    end else begin
      phase_r     <= phase_nxt;
      pv_r        <= (state_nxt == ST_MON);
      chg_r       <= chg_nxt;
      fault_r     <= fault_nxt;
      code_r      <= code_nxt;
      dwell       <= dwell_nxt;
      first_phase <= first_nxt;
    end
  end

  assign mon.phase        = phase_r;
  assign mon.phase_valid  = pv_r;
  assign mon.phase_change = chg_r;
  assign mon.fault        = fault_r;
  assign mon.fault_code   = code_r;

`ifdef TRAFFIC_MON_STATS_EN
  logic [15:0] cyc_cnt;
  // chg_nxt only fires on a legal step in MON, so phase 11 means 11->00
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cyc_cnt <= 16'h0000;
    else if (chg_nxt && phase_r == 2'd3 && cyc_cnt != 16'hFFFF)
      cyc_cnt <= cyc_cnt + 16'h0001;
  end
  assign mon.cycle_count = cyc_cnt;
`else
  assign mon.cycle_count = 16'h0000;
`endif

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Receive-side checker for the two-road light controller. Decodes `light_hospital` / `light_highway` back into the controller phase and tracks the phase sequence.
- Measures the dwell time of each phase in 1 s ticks. Flags encoding, conflict, sequence and timing violations with a sticky fault code.
- Sits beside the controller in the top level and in the testbench, observing the controller's outputs only.

Parameters:
- TICK_DIV, 4, clk cycles per tick; internal prescaler emits one tick when its counter equals TICK_DIV-1.
- YEL_TICKS, 3, nominal yellow dwell in ticks (either road).
- GRN_TICKS, 10, nominal highway-green dwell in ticks.
- TOL, 1, allowed dwell deviation in ticks, plus or minus.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- light_hospital  input  3  {red,yellow,green}: 100 red, 010 yellow, 001 green
- light_highway  input  3  same encoding
- fault_clr  input  1  one-cycle pulse; clears fault and resyncs
- phase  output  2  00 HGRE_FRED, 01 HYEL_FRED, 10 HRED_FGRE, 11 HRED_FYEL
- phase_valid  output  1  monitor is locked to a legal phase
- phase_change  output  1  one-cycle pulse on each legal phase transition
- fault  output  1  sticky fault flag
- fault_code  output  3  first fault captured (0 = none)
- cycle_count  output  16  completed full cycles (see Optional Feature)

Behaviour:
- Reset (async, active-low) values:
  - phase=00, phase_valid=0, phase_change=0, fault=0, fault_code=0, cycle_count=0.
  - Prescaler=0, dwell=0, state=SYNC.
- Input path: both light buses are registered once. Decode and checks use the registered copy; all outputs are registered. Latency from input change to phase/phase_change/fault is 2 clk.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 for the one cycle where count==TICK_DIV-1.
- Legal pairs (hospital, highway): (001,100)=00, (010,100)=01, (100,001)=10, (100,010)=11.
- Fault codes, in priority order (lowest code wins when several occur in the same cycle):
  - 1 ILLEGAL_ENC: either bus not one-hot.
  - 2 CONFLICT: both buses one-hot and neither red.
  - 3 BAD_SEQ: legal phase other than current or current+1 (mod 4).
  - 4 DWELL_SHORT: yellow or highway-green exited with dwell < nominal-TOL.
  - 5 DWELL_LONG: dwell > nominal+TOL while still in phase. Raised on the tick that crosses the limit, not at exit.
- Phase 00 (hospital green) has no dwell limit.
- FSM states:
  - SYNC: phase_valid=0, no checks except codes 1 and 2. The first legal pair loads phase, sets phase_valid=1, clears dwell, sets first_phase=1, and moves to MON. No phase_change pulse on lock.
  - MON:
    - Dwell increments on tick and saturates at 255.
    - On a legal next phase: phase_change=1, phase updates, and dwell restarts at 0. If the tick lands in the same cycle, dwell counts it as 1.
    - DWELL_SHORT is skipped on exit when first_phase=1. first_phase clears on the first transition.
    - Any fault: fault=1, fault_code latched, state goes to FAULT.
  - FAULT: phase_valid=0, phase holds its last value, and further faults are ignored (fault_code keeps the first). fault_clr clears fault and fault_code and moves to SYNC.
- fault_clr in SYNC or MON clears fault/fault_code. It has no effect on tracking.
- fault_clr coinciding with a new fault: the new fault is captured and the clear is lost.
- Reset mid-operation returns every register to its reset value immediately, whatever the state.

Optional Feature:
- Macro: TRAFFIC_MON_STATS_EN.
- Defined:
  - cycle_count increments on each legal 11→00 transition in MON and saturates at 16'hFFFF.
  - Cleared by reset only; fault_clr does not clear it.
- Undefined: the counter is not built and cycle_count is driven 16'h0000. The port list is unchanged.

Test Plan:
- Nominal loop, defaults:
  - Stimulus: drive 00 for 20 ticks, then 01 for 3 ticks, 10 for 10 ticks, 11 for 3 ticks, and back to 00; repeat 3 times.
  - Response: phase steps 00→01→10→11→00 two clk after each input change, and 12 phase_change pulses are counted (the initial lock does not pulse). fault=0 throughout; cycle_count=3 with the macro, 0 without.
- Illegal encoding: drive hospital=011 while in MON → fault=1, fault_code=1, phase_valid=0 two clk later. A later conflict (001,001) leaves fault_code at 1.
- Sequence skip: in phase 01, jump to 11 → fault_code=3. Pulse fault_clr, then drive (001,100) → phase_valid=1, phase=00, fault=0.
- Dwell bounds:
  - Highway green held 8 ticks, then 11 → fault_code=4.
  - Separate run, highway green held 12 ticks → fault_code=5 on the 12th tick, with no phase change.
- Lock mid-cycle: release reset with inputs at (100,001) held 2 ticks, then 11 → locks to phase=10 and exits with no fault (first_phase skip).
- Reset mid-cycle: assert rst_n=0 during phase 10 → all outputs zero asynchronously; after release, state is SYNC.
